// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - debounced button levels to press/release/long/repeat pulses and event stream
module button_event_gen #(
  parameter int p_PORT_WIDTH    = 4,
  parameter int p_LONG_CLOCKS   = 2**24,
  parameter int p_REPEAT_CLOCKS = 2**22
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [p_PORT_WIDTH-1:0] in_btn,
  output logic [p_PORT_WIDTH-1:0] on_press,
  output logic [p_PORT_WIDTH-1:0] on_release,
  output logic [p_PORT_WIDTH-1:0] on_long,
  output logic [p_PORT_WIDTH-1:0] on_repeat,
  output logic                    o_evt_valid,
  input  logic                    i_evt_ready,
  output logic [((p_PORT_WIDTH > 1) ? $clog2(p_PORT_WIDTH) : 1)-1:0] on_evt_chan,
  output logic [1:0]              on_evt_type,
  output logic                    o_overflow,
  input  logic                    i_ovf_clr
);

  localparam int CHW  = (p_PORT_WIDTH > 1) ? $clog2(p_PORT_WIDTH) : 1;
  localparam int MAXC = (p_LONG_CLOCKS > p_REPEAT_CLOCKS) ? p_LONG_CLOCKS : p_REPEAT_CLOCKS;
  localparam int CNTW = $clog2(MAXC);
  localparam logic [CNTW-1:0] LONG_LAST   = CNTW'(p_LONG_CLOCKS - 1);
  localparam logic [CNTW-1:0] REPEAT_LAST = CNTW'(p_REPEAT_CLOCKS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} state_t;

  // Next-cycle pulse values; registered into the on_* outputs.
  logic [p_PORT_WIDTH-1:0] press_d, release_d, long_d, repeat_d;

  for (genvar c = 0; c < p_PORT_WIDTH; c++) begin : g_chan
    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            prev_q;
    logic            press_l, release_l, long_l, repeat_l;

    // Per-channel state, hold counter and previous level.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        prev_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        prev_q  <= in_btn[c];
      end
    end

    // Press detection, hold timing; a release beats a same-cycle threshold.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_l   = 1'b0;
      release_l = 1'b0;
      long_l    = 1'b0;
      repeat_l  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_btn[c] && !prev_q) begin
            press_l = 1'b1;
            cnt_d   = '0;
            state_d = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!in_btn[c]) begin
            release_l = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else if (cnt_q == LONG_LAST) begin
            long_l  = 1'b1;
            cnt_d   = '0;
            state_d = ST_LONG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LONG: begin
          if (!in_btn[c]) begin
            release_l = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else if (cnt_q == REPEAT_LAST) begin
            repeat_l = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign press_d[c]   = press_l;
    assign release_d[c] = release_l;
    assign long_d[c]    = long_l;
    assign repeat_d[c]  = repeat_l;
  end

  // Pending bits indexed by event type code: [0] press, [1] release, [2] long, [3] repeat.
  logic [p_PORT_WIDTH-1:0][3:0] pend_q, pend_d, new_evt, clr_mask;
  logic                         sel_found, load, lost;
  logic [CHW-1:0]               sel_chan;
  logic [1:0]                   sel_type;

  assign load = !o_evt_valid || i_evt_ready;

  // Gather this cycle's new events per channel.
  always_comb begin
    new_evt = '0;
    for (int c = 0; c < p_PORT_WIDTH; c++) begin
      new_evt[c] = {repeat_d[c], long_d[c], release_d[c], press_d[c]};
    end
  end

  // Pick the lowest channel with pending work; press > release > long > repeat.
  always_comb begin
    sel_found = 1'b0;
    sel_chan  = '0;
    sel_type  = 2'd0;
    for (int c = p_PORT_WIDTH - 1; c >= 0; c--) begin
      if (|pend_q[c]) begin
        sel_found = 1'b1;
        sel_chan  = CHW'(c);
        if (pend_q[c][0])      sel_type = 2'd0;
        else if (pend_q[c][1]) sel_type = 2'd1;
        else if (pend_q[c][2]) sel_type = 2'd2;
        else                   sel_type = 2'd3;
      end
    end
  end

  // Clear the bit being moved into the output register; flag pulses hitting an occupied bit.
  always_comb begin
    clr_mask = '0;
    if (load && sel_found) begin
      clr_mask[sel_chan][sel_type] = 1'b1;
    end
    pend_d = (pend_q & ~clr_mask) | new_evt;
    lost   = |(new_evt & pend_q & ~clr_mask);
  end

  // Registered pulses, pending set, stream output word and sticky overflow.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      on_press    <= '0;
      on_release  <= '0;
      on_long     <= '0;
      on_repeat   <= '0;
      pend_q      <= '0;
      o_evt_valid <= 1'b0;
      on_evt_chan <= '0;
      on_evt_type <= 2'd0;
      o_overflow  <= 1'b0;
    end else begin
      on_press   <= press_d;
      on_release <= release_d;
      on_long    <= long_d;
      on_repeat  <= repeat_d;
      pend_q     <= pend_d;
      if (load) begin
        o_evt_valid <= sel_found;
        if (sel_found) begin
          on_evt_chan <= sel_chan;
          on_evt_type <= sel_type;
        end
      end
      o_overflow <= lost || (o_overflow && !i_ovf_clr);
    end
  end

endmodule
